idex_seg_reg: RTL and testbench

//  ID/EX pipeline segment register of the RISC-V pipeline CPU. Downstream neighbour of the ID-stage

---
 rtl/idex_seg_reg_if.sv | 71 +++++++
 rtl/idex_seg_reg.sv | 104 ++++++++++
 tb/tb_idex_seg_reg.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/idex_seg_reg_if.sv
// ID/EX segment bundle: hazard controls, D-stage inputs and E-stage outputs.
// Latency: none (wiring only); backpressure: en=0 stalls, clear=1 flushes the register.
// master = ID/hazard side driving D fields; slave = the segment register driving E fields.
interface idex_seg_reg_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              en;
    logic              clear;

    logic              ValidD;
    logic [XLEN-1:0]   PCD;
    logic [XLEN-1:0]   ImmD;
    logic [XLEN-1:0]   RegOut1D;
    logic [XLEN-1:0]   RegOut2D;
    logic [REG_AW-1:0] RdD;
    logic [REG_AW-1:0] Rs1D;
    logic [REG_AW-1:0] Rs2D;
    logic              JalrD;
    logic [2:0]        RegWriteD;
    logic              MemToRegD;
    logic [3:0]        MemWriteD;
    logic              LoadNpcD;
    logic [1:0]        RegReadD;
    logic [2:0]        BranchTypeD;
    logic [3:0]        AluContrlD;
    logic              AluSrc1D;
    logic [1:0]        AluSrc2D;

    logic              ValidE;
    logic [XLEN-1:0]   PCE;
    logic [XLEN-1:0]   ImmE;
    logic [XLEN-1:0]   RegOut1E;
    logic [XLEN-1:0]   RegOut2E;
    logic [REG_AW-1:0] RdE;
    logic [REG_AW-1:0] Rs1E;
    logic [REG_AW-1:0] Rs2E;
    logic              JalrE;
    logic [2:0]        RegWriteE;
    logic              MemToRegE;
    logic [3:0]        MemWriteE;
    logic              LoadNpcE;
    logic [1:0]        RegReadE;
    logic [2:0]        BranchTypeE;
    logic [3:0]        AluContrlE;
    logic              AluSrc1E;
    logic [1:0]        AluSrc2E;
    logic [31:0]       PerfCntE;

    modport master (
        output en, clear,
        output ValidD, PCD, ImmD, RegOut1D, RegOut2D, RdD, Rs1D, Rs2D,
        output JalrD, RegWriteD, MemToRegD, MemWriteD, LoadNpcD,
        output RegReadD, BranchTypeD, AluContrlD, AluSrc1D, AluSrc2D,
        input  ValidE, PCE, ImmE, RegOut1E, RegOut2E, RdE, Rs1E, Rs2E,
        input  JalrE, RegWriteE, MemToRegE, MemWriteE, LoadNpcE,
        input  RegReadE, BranchTypeE, AluContrlE, AluSrc1E, AluSrc2E,
        input  PerfCntE
    );

    modport slave (
        input  en, clear,
        input  ValidD, PCD, ImmD, RegOut1D, RegOut2D, RdD, Rs1D, Rs2D,
        input  JalrD, RegWriteD, MemToRegD, MemWriteD, LoadNpcD,
        input  RegReadD, BranchTypeD, AluContrlD, AluSrc1D, AluSrc2D,
        output ValidE, PCE, ImmE, RegOut1E, RegOut2E, RdE, Rs1E, Rs2E,
        output JalrE, RegWriteE, MemToRegE, MemWriteE, LoadNpcE,
        output RegReadE, BranchTypeE, AluContrlE, AluSrc1E, AluSrc2E,
        output PerfCntE
    );
endinterface

// File: rtl/idex_seg_reg.sv
// ID/EX pipeline segment register; optional instruction counter under IDEX_PERF_CNT_EN.
// Latency: 1 cycle D->E, no combinational path.
// Backpressure: en=0 holds the E slot indefinitely; clear=1 loads an all-zero bubble over en.
module idex_seg_reg #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    idex_seg_reg_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   rs1_dat;
        logic [XLEN-1:0]   rs2_dat;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              jalr;
        logic [2:0]        reg_write;
        logic              mem_to_reg;
        logic [3:0]        mem_write;
        logic              load_npc;
        logic [1:0]        reg_read;
        logic [2:0]        branch_type;
        logic [3:0]        alu_ctrl;
        logic              alu_src1;
        logic [1:0]        alu_src2;
    } stage_t;

    stage_t d_stage;
    stage_t e_stage;

    always_comb begin
        d_stage             = '0;
        d_stage.valid       = bus.ValidD;
        d_stage.pc          = bus.PCD;
        d_stage.imm         = bus.ImmD;
        d_stage.rs1_dat     = bus.RegOut1D;
        d_stage.rs2_dat     = bus.RegOut2D;
        d_stage.rd          = bus.RdD;
        d_stage.rs1         = bus.Rs1D;
        d_stage.rs2         = bus.Rs2D;
        d_stage.jalr        = bus.JalrD;
        d_stage.reg_write   = bus.RegWriteD;
        d_stage.mem_to_reg  = bus.MemToRegD;
        d_stage.mem_write   = bus.MemWriteD;
        d_stage.load_npc    = bus.LoadNpcD;
        d_stage.reg_read    = bus.RegReadD;
        d_stage.branch_type = bus.BranchTypeD;
        d_stage.alu_ctrl    = bus.AluContrlD;
        d_stage.alu_src1    = bus.AluSrc1D;
        d_stage.alu_src2    = bus.AluSrc2D;
    end

    // All-zero is the bubble encoding: no write-back, no store, no branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_stage <= '0;
        end else if (bus.clear) begin
            e_stage <= '0;
        end else if (bus.en) begin
            e_stage <= d_stage;
        end
    end

    assign bus.ValidE      = e_stage.valid;
    assign bus.PCE         = e_stage.pc;
    assign bus.ImmE        = e_stage.imm;
    assign bus.RegOut1E    = e_stage.rs1_dat;
    assign bus.RegOut2E    = e_stage.rs2_dat;
    assign bus.RdE         = e_stage.rd;
    assign bus.Rs1E        = e_stage.rs1;
    assign bus.Rs2E        = e_stage.rs2;
    assign bus.JalrE       = e_stage.jalr;
    assign bus.RegWriteE   = e_stage.reg_write;
    assign bus.MemToRegE   = e_stage.mem_to_reg;
    assign bus.MemWriteE   = e_stage.mem_write;
    assign bus.LoadNpcE    = e_stage.load_npc;
    assign bus.RegReadE    = e_stage.reg_read;
    assign bus.BranchTypeE = e_stage.branch_type;
    assign bus.AluContrlE  = e_stage.alu_ctrl;
    assign bus.AluSrc1E    = e_stage.alu_src1;
    assign bus.AluSrc2E    = e_stage.alu_src2;

`ifdef IDEX_PERF_CNT_EN
    // Counts real instructions entering EX; a flush does not rewind it.
    logic [31:0] perf_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt <= '0;
        end else if (!bus.clear && bus.en && bus.ValidD) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign bus.PerfCntE = perf_cnt;
`else
    assign bus.PerfCntE = 32'd0;
`endif
endmodule

// File: tb/tb_idex_seg_reg.sv
// Randomized self-checking bench for idex_seg_reg against a per-edge slot model.
// Honours IDEX_PERF_CNT_EN for the expected counter behaviour.
module tb_idex_seg_reg;
    localparam int W = 166;
    localparam logic [2:0] RW_LW = 3'd5;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    bit   chk_en;

    idex_seg_reg_if #(.XLEN(32), .REG_AW(5)) bus ();

    idex_seg_reg #(.XLEN(32), .REG_AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pack_d();
        return {bus.ValidD, bus.PCD, bus.ImmD, bus.RegOut1D, bus.RegOut2D, bus.RdD, bus.Rs1D,
                bus.Rs2D, bus.JalrD, bus.RegWriteD, bus.MemToRegD, bus.MemWriteD, bus.LoadNpcD,
                bus.RegReadD, bus.BranchTypeD, bus.AluContrlD, bus.AluSrc1D, bus.AluSrc2D};
    endfunction

    function automatic logic [W-1:0] pack_e();
        return {bus.ValidE, bus.PCE, bus.ImmE, bus.RegOut1E, bus.RegOut2E, bus.RdE, bus.Rs1E,
                bus.Rs2E, bus.JalrE, bus.RegWriteE, bus.MemToRegE, bus.MemWriteE, bus.LoadNpcE,
                bus.RegReadE, bus.BranchTypeE, bus.AluContrlE, bus.AluSrc1E, bus.AluSrc2E};
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the E slot is whatever D was at the last edge that took it, zero after
    // reset or flush; the counter is the number of valid captures since reset (plus a preset bias).
    logic [W-1:0] exp_e;
    logic [31:0]  n_cap;
    logic [31:0]  bias;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_e = '0;
            n_cap = 32'd0;
        end else begin
            if (bus.clear)   exp_e = '0;
            else if (bus.en) exp_e = pack_d();
            if (!bus.clear && bus.en && bus.ValidD) n_cap = n_cap + 32'd1;
        end
    end

    function automatic logic [31:0] exp_perf();
`ifdef IDEX_PERF_CNT_EN
        return n_cap + bias;
`else
        return 32'd0;
`endif
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_e", pack_e(), exp_e);
            chk("model_perf", W'(bus.PerfCntE), W'(exp_perf()));
        end
    end

    task automatic rand_d();
        bus.ValidD      = 1'($urandom);
        bus.PCD         = $urandom;
        bus.ImmD        = $urandom;
        bus.RegOut1D    = $urandom;
        bus.RegOut2D    = $urandom;
        bus.RdD         = 5'($urandom);
        bus.Rs1D        = 5'($urandom);
        bus.Rs2D        = 5'($urandom);
        bus.JalrD       = 1'($urandom);
        bus.RegWriteD   = 3'($urandom);
        bus.MemToRegD   = 1'($urandom);
        bus.MemWriteD   = 4'($urandom);
        bus.LoadNpcD    = 1'($urandom);
        bus.RegReadD    = 2'($urandom);
        bus.BranchTypeD = 3'($urandom);
        bus.AluContrlD  = 4'($urandom);
        bus.AluSrc1D    = 1'($urandom);
        bus.AluSrc2D    = 2'($urandom);
    endtask

    task automatic ones_d();
        bus.ValidD = '1; bus.PCD = '1; bus.ImmD = '1; bus.RegOut1D = '1; bus.RegOut2D = '1;
        bus.RdD = '1; bus.Rs1D = '1; bus.Rs2D = '1; bus.JalrD = '1; bus.RegWriteD = '1;
        bus.MemToRegD = '1; bus.MemWriteD = '1; bus.LoadNpcD = '1; bus.RegReadD = '1;
        bus.BranchTypeD = '1; bus.AluContrlD = '1; bus.AluSrc1D = '1; bus.AluSrc2D = '1;
    endtask

    logic [W-1:0] snap;
    logic [W-1:0] all_ones;

    initial begin
        n_checks = 0;
        n_errors = 0;
        chk_en   = 1'b0;
        bias     = 32'd0;
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.clear = 1'b0;
        ones_d();
        all_ones = pack_d();
        repeat (2) @(negedge clk);
        chk("reset_e", pack_e(), '0);
        chk("reset_perf", W'(bus.PerfCntE), '0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Async reset mid-cycle with all-ones D inputs.
        bus.en = 1'b1;
        @(posedge clk);
        #2;
        chk("ones_captured", pack_e(), all_ones);
        rst_n = 1'b0;
        #1;
        chk("async_reset_e", pack_e(), '0);
        chk("async_reset_valid", W'(bus.ValidE), '0);
        chk("async_reset_perf", W'(bus.PerfCntE), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Capture.
        rand_d();
        bus.ValidD = 1'b1; bus.PCD = 32'h0000_0040; bus.ImmD = 32'hFFFF_FFF0;
        bus.RegWriteD = RW_LW; bus.RdD = 5'd5;
        bus.en = 1'b1; bus.clear = 1'b0;
        @(negedge clk);
        chk("cap_pc", W'(bus.PCE), W'(32'h40));
        chk("cap_imm", W'(bus.ImmE), W'(32'hFFFF_FFF0));
        chk("cap_regwrite", W'(bus.RegWriteE), W'(RW_LW));
        chk("cap_rd", W'(bus.RdE), W'(5'd5));
        chk("cap_valid", W'(bus.ValidE), W'(1'b1));
        snap = pack_e();

        // Stall holds while D changes.
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_d();
            @(negedge clk);
            chk("stall_hold", pack_e(), snap);
        end

        // Flush overrides stall.
        bus.clear = 1'b1; bus.MemWriteD = 4'b1111; bus.RegWriteD = 3'd7; bus.ValidD = 1'b1;
        @(negedge clk);
        chk("flush_memwrite", W'(bus.MemWriteE), '0);
        chk("flush_regwrite", W'(bus.RegWriteE), '0);
        chk("flush_branch", W'(bus.BranchTypeE), '0);
        chk("flush_valid", W'(bus.ValidE), '0);
        @(negedge clk);
        chk("flush_repeat", pack_e(), '0);

        // Counter: 10 valid captures, 2 bubbles, 1 clear.
        rst_n = 1'b0;
        bus.clear = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            rand_d();
            bus.ValidD = (i < 10) || (i == 12);
            bus.clear  = (i == 12);
            @(negedge clk);
        end
        bus.en = 1'b0; bus.clear = 1'b0;
        @(negedge clk);
`ifdef IDEX_PERF_CNT_EN
        chk("perf_ten", W'(bus.PerfCntE), W'(32'd10));
        @(posedge clk);
        #2;
        force dut.perf_cnt = 32'hFFFF_FFFF;
        release dut.perf_cnt;
        bias = 32'hFFFF_FFFF - n_cap;
        bus.en = 1'b1; bus.ValidD = 1'b1;
        @(negedge clk);
        chk("perf_preset", W'(bus.PerfCntE), W'(32'hFFFF_FFFF));
        @(negedge clk);
        chk("perf_wrap", W'(bus.PerfCntE), W'(32'd0));
        bus.en = 1'b0;
        rst_n = 1'b0;
        #1;
        bias = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
`else
        chk("perf_absent", W'(bus.PerfCntE), W'(32'd0));
`endif

        // Randomized phase with occasional async resets.
        for (int i = 0; i < 600; i++) begin
            rand_d();
            bus.en    = ($urandom_range(3) != 0);
            bus.clear = ($urandom_range(7) == 0);
            rst_n     = 1'b1;
            if ($urandom_range(59) == 0) begin
                #2;
                rst_n = 1'b0;
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
